// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one external 32-bit ALU between two requesters, with a single
// registered response slot and one architectural NZCV flag register per requester.
module alu_share_ctrl #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [1:0]  req0_op_i,
  input  logic        req0_s_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [1:0]  req1_op_i,
  input  logic        req1_s_i,

  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [1:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_n_i,
  input  logic        alu_z_i,
  input  logic        alu_c_i,
  input  logic        alu_v_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic [3:0]  rsp_flags_o,

  output logic [3:0]  flags0_o,
  output logic [3:0]  flags1_o
);

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e       slot_q, slot_d;
  logic        last_q, last_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [3:0]  flags0_q, flags0_d;
  logic [3:0]  flags1_q, flags1_d;

  logic       can_issue;
  logic       grant;
  logic       accept;
  logic       sel_s;
  logic [1:0] sel_op;
  logic [3:0] alu_flags;
  logic [3:0] upd_flags;

  // Logical ops only own N and Z; C and V come from the requester's previous flags.
  function automatic logic [3:0] merge_flags(input logic [3:0] old_f, input logic [1:0] op,
                                             input logic [3:0] raw_f);
    return op[1] ? {raw_f[3:2], old_f[1:0]} : raw_f;
  endfunction

  always_comb begin
    can_issue = (slot_q == StEmpty) || rsp_ready_i;
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid_i;
    end
    req0_ready_o = can_issue && !grant && req0_valid_i;
    req1_ready_o = can_issue && grant && req1_valid_i;
    accept       = req0_ready_o || req1_ready_o;

    alu_a_o    = grant ? req1_a_i  : req0_a_i;
    alu_b_o    = grant ? req1_b_i  : req0_b_i;
    alu_ctrl_o = grant ? req1_op_i : req0_op_i;
    sel_op     = alu_ctrl_o;
    sel_s      = grant ? req1_s_i  : req0_s_i;
    alu_flags  = {alu_n_i, alu_z_i, alu_c_i, alu_v_i};
    upd_flags  = merge_flags(grant ? flags1_q : flags0_q, sel_op, alu_flags);
  end

  always_comb begin
    slot_d       = slot_q;
    last_d       = last_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    flags0_d     = flags0_q;
    flags1_d     = flags1_q;

    unique case (slot_q)
      StEmpty: if (accept) slot_d = StFull;
      StFull:  if (!accept && rsp_ready_i) slot_d = StEmpty;
      default: slot_d = StEmpty;
    endcase

    if (accept) begin
      last_d       = grant;
      rsp_id_d     = grant;
      rsp_result_d = alu_result_i;
      rsp_flags_d  = alu_flags;
      if (sel_s) begin
        if (grant) flags1_d = upd_flags;
        else       flags0_d = upd_flags;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q       <= StEmpty;
      last_q       <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flags0_q     <= FLAG_RST;
      flags1_q     <= FLAG_RST;
    end else begin
      slot_q       <= slot_d;
      last_q       <= last_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      flags0_q     <= flags0_d;
      flags1_q     <= flags1_d;
    end
  end

  assign rsp_valid_o  = (slot_q == StFull);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign flags0_o     = flags0_q;
  assign flags1_o     = flags1_q;

endmodule
